// File: rtl/stack_pkg.sv
// Shared definitions for the stack command sequencer and the external stack:
// op encoding, sequencer state encoding and the default stack capacity.
package stack_pkg;

  localparam int unsigned DEPTH_MAX = 5;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_GET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/stack_occ_counter.sv
// Saturating stack occupancy counter with synchronous clear and
// full/empty flags.
module stack_occ_counter #(
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned DEPTH_MAX = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [IDX_W-1:0] o_occ,
  output logic             o_full,
  output logic             o_empty
);

  logic [IDX_W-1:0] r_occ;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_occ >= IDX_W'(DEPTH_MAX));
  assign w_empty = (r_occ == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (i_clr) begin
      r_occ <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_occ <= r_occ + 1'b1;
    end else if (i_dec && !i_inc && !w_empty) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  assign o_occ   = r_occ;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Request/response front end that issues one command at a time to an
// external stack over a shared bidirectional data bus.
module stack_cmd_sequencer #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned DEPTH_MAX = stack_pkg::DEPTH_MAX
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [DATA_W-1:0] REQ_DATA,
  input  logic [IDX_W-1:0]  REQ_INDEX,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic [IDX_W-1:0]  OCC,
  output logic [1:0]        COMMAND,
  output logic [IDX_W-1:0]  INDEX,
  inout  logic [DATA_W-1:0] IO_DATA,
  output logic              STK_RESET
);

  import stack_pkg::*;

  state_e            r_state;
  op_e               r_op;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_index;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_armed;

  op_e               w_req_op;
  logic [IDX_W-1:0]  w_occ;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_reject;
  logic              w_inc;
  logic              w_dec;
  logic              w_issue;

  stack_occ_counter #(
    .IDX_W     (IDX_W),
    .DEPTH_MAX (DEPTH_MAX)
  ) u_occ (
    .clk     (CLK),
    .rst_n   (RESET),
    .i_clr   (1'b0),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_occ   (w_occ),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_req_op = op_e'(REQ_OP);
  // r_armed keeps REQ_READY low until the first edge after reset release.
  assign REQ_READY = r_armed && (r_state == ST_IDLE);
  assign w_accept  = REQ_VALID && REQ_READY;
  assign w_issue   = (r_state == ST_ISSUE);
  assign w_inc     = w_issue && (r_op == OP_PUSH);
  assign w_dec     = w_issue && (r_op == OP_POP);

  always_comb begin
    w_reject = 1'b0;
    case (w_req_op)
      OP_PUSH: w_reject = w_full;
      OP_POP:  w_reject = w_empty;
      OP_GET:  w_reject = (REQ_INDEX >= w_occ);
      default: w_reject = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NOP;
      r_data     <= '0;
      r_index    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= w_req_op;
            r_data     <= REQ_DATA;
            r_index    <= REQ_INDEX;
            r_rsp_data <= '0;
            r_rsp_err  <= w_reject;
            if (w_reject || (w_req_op == OP_NOP)) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= (r_op == OP_PUSH) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          r_rsp_data <= IO_DATA;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (RSP_READY) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RSP_VALID = (r_state == ST_RESP);
  assign RSP_DATA  = r_rsp_data;
  assign RSP_ERR   = r_rsp_err;
  assign OCC       = w_occ;
  assign COMMAND   = w_issue ? r_op : OP_NOP;
  assign INDEX     = (w_issue && (r_op == OP_GET)) ? r_index : '0;
  assign IO_DATA   = w_inc ? r_data : 'z;
  assign STK_RESET = ~RESET;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed bench: table of requests with hand-computed responses, plus
// sequences for reset during WAIT and a stalled response.
module tb_stack_cmd_sequencer;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] GET  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_data = '0;
  logic [2:0] req_index = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [2:0] occ;
  logic [1:0] command;
  logic [2:0] index;
  wire  [3:0] io_data;
  logic       stk_reset;

  int errors = 0;
  int checks = 0;
  int obs_ncmd;
  int obs_bad;

  always #5 clk = ~clk;

  stack_cmd_sequencer #(
    .DATA_W    (4),
    .IDX_W     (3),
    .DEPTH_MAX (5)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_OP    (req_op),
    .REQ_DATA  (req_data),
    .REQ_INDEX (req_index),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_DATA  (rsp_data),
    .RSP_ERR   (rsp_err),
    .OCC       (occ),
    .COMMAND   (command),
    .INDEX     (index),
    .IO_DATA   (io_data),
    .STK_RESET (stk_reset)
  );

  // Undriven bus reads as all ones.
  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup (io_data[g]);
  end

  // External stack model: executes at the edge ending ISSUE, drives result next cycle.
  logic [3:0] mem [0:7];
  int         sp = 0;
  logic       stk_drv = 1'b0;
  logic [3:0] stk_q = '0;

  assign io_data = stk_drv ? stk_q : 4'bzzzz;

  always @(posedge clk or posedge stk_reset) begin
    if (stk_reset) begin
      sp      <= 0;
      stk_drv <= 1'b0;
    end else begin
      stk_drv <= 1'b0;
      case (command)
        PUSH: begin
          mem[sp & 7] <= io_data;
          sp          <= sp + 1;
        end
        POP: begin
          stk_q   <= mem[(sp - 1) & 7];
          stk_drv <= 1'b1;
          sp      <= sp - 1;
        end
        GET: begin
          stk_q   <= mem[(sp - 1 - int'(index)) & 7];
          stk_drv <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] idx;
    logic       err;
    logic [3:0] rdata;
    int         lat;
    int         occ;
    int         ncmd;
    int         hold;
  } vec_t;

  vec_t vecs [0:19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] data);
    if (command != NOP) begin
      obs_ncmd++;
      if (command != op || index != ((op == GET) ? idx : 3'd0)) obs_bad++;
      if (op == PUSH) begin
        if (io_data != data) obs_bad++;
      end else if (io_data != 4'hF) begin
        obs_bad++;
      end
    end else begin
      if (index != 3'd0) obs_bad++;
      if (!stk_drv && io_data != 4'hF) obs_bad++;
    end
  endtask

  // Called at a negedge with the sequencer idle; returns at a negedge.
  task automatic run_req(input vec_t v, input string tag);
    int         lat;
    int         unstable;
    logic [3:0] d0;
    logic       e0;
    obs_ncmd = 0;
    obs_bad  = 0;
    unstable = 0;
    chk({tag, " req_ready"}, int'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_data  = v.data;
    req_index = v.idx;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = NOP;
    req_data  = '0;
    req_index = '0;
    lat = 1;
    forever begin
      observe(v.op, v.idx, v.data);
      if (rsp_valid || lat >= 8) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " rsp_err"}, int'(rsp_err), int'(v.err));
    chk({tag, " rsp_data"}, int'(rsp_data), int'(v.rdata));
    d0 = rsp_data;
    e0 = rsp_err;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      observe(v.op, v.idx, v.data);
      if (!rsp_valid || rsp_data != d0 || rsp_err != e0 || req_ready) unstable++;
    end
    if (v.hold > 0) chk({tag, " rsp_stable"}, unstable, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " occ"}, int'(occ), v.occ);
    chk({tag, " cmd_count"}, obs_ncmd, v.ncmd);
    chk({tag, " bus_cmd_obs"}, obs_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       w;
    for (int i = 0; i < 5; i++)
      vecs[i] = '{PUSH, 4'(i + 1), 3'd0, 1'b0, 4'd0, 2, i + 1, 1, 0};
    vecs[5] = '{PUSH, 4'd6, 3'd0, 1'b1, 4'd0, 1, 5, 0, 0};
    for (int i = 0; i < 5; i++)
      vecs[6 + i] = '{GET, 4'd0, 3'(i), 1'b0, 4'(5 - i), 3, 5, 1, (i == 2) ? 4 : 0};
    vecs[11] = '{GET, 4'd0, 3'd5, 1'b1, 4'd0, 1, 5, 0, 0};
    vecs[12] = '{NOP, 4'd0, 3'd0, 1'b0, 4'd0, 1, 5, 0, 0};
    for (int i = 0; i < 5; i++)
      vecs[13 + i] = '{POP, 4'd0, 3'd0, 1'b0, 4'(5 - i), 3, 4 - i, 1, 0};
    vecs[18] = '{POP, 4'd0, 3'd0, 1'b1, 4'd0, 1, 0, 0, 4};
    vecs[19] = '{GET, 4'd0, 3'd0, 1'b1, 4'd0, 1, 0, 0, 0};

    repeat (2) @(negedge clk);
    chk("reset req_ready", int'(req_ready), 0);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_data", int'(rsp_data), 0);
    chk("reset rsp_err", int'(rsp_err), 0);
    chk("reset occ", int'(occ), 0);
    chk("reset command", int'(command), 0);
    chk("reset index", int'(index), 0);
    chk("reset io_data_z", int'(io_data), 15);
    chk("reset stk_reset", int'(stk_reset), 1);
    rst_n = 1'b1;
    #1;
    chk("release stk_reset", int'(stk_reset), 0);
    chk("release req_ready_before_edge", int'(req_ready), 0);
    @(negedge clk);
    chk("release req_ready_after_edge", int'(req_ready), 1);

    for (int i = 0; i < 20; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while a POP is in WAIT.
    run_req('{PUSH, 4'd9, 3'd0, 1'b0, 4'd0, 2, 1, 1, 0}, "pre_rst push");
    req_valid = 1'b1;
    req_op    = POP;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = NOP;
    chk("midrst issue_cmd", int'(command), int'(POP));
    @(negedge clk);
    chk("midrst wait_bus", int'(io_data), 9);
    rst_n = 1'b0;
    #1;
    chk("midrst req_ready", int'(req_ready), 0);
    chk("midrst rsp_valid", int'(rsp_valid), 0);
    chk("midrst occ", int'(occ), 0);
    chk("midrst command", int'(command), 0);
    chk("midrst io_data_z", int'(io_data), 15);
    chk("midrst stk_reset", int'(stk_reset), 1);
    @(negedge clk);
    chk("midrst rsp_valid_held", int'(rsp_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    w = '{PUSH, 4'd7, 3'd0, 1'b0, 4'd0, 2, 1, 1, 0};
    run_req(w, "post_rst push7");
    w = '{GET, 4'd0, 3'd0, 1'b0, 4'd7, 3, 1, 1, 0};
    run_req(w, "post_rst get0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_cmd_sequencer.md
STACK_CMD_SEQUENCER -- requirements
Module: stack_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 4: stack data width.
REQ-002 SHALL have parameter IDX_W, default 3: stack index width.
REQ-003 SHALL have parameter DEPTH_MAX, default 5: stack capacity in entries.
REQ-004 SHALL have CLK, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have REQ_VALID, input, 1 bit: request present.
REQ-007 SHALL have REQ_READY, output, 1 bit: request accepted when high together with REQ_VALID.
REQ-008 SHALL have REQ_OP, input, 2 bits: NOP=00, PUSH=01, POP=10, GET=11.
REQ-009 SHALL have REQ_DATA, input, DATA_W bits: push operand.
REQ-010 SHALL have REQ_INDEX, input, IDX_W bits: GET index, where 0 is the top of stack.
REQ-011 SHALL have RSP_VALID, output, 1 bit: response present.
REQ-012 SHALL have RSP_READY, input, 1 bit: response consumed.
REQ-013 SHALL have RSP_DATA, output, DATA_W bits: POP/GET result, otherwise 0.
REQ-014 SHALL have RSP_ERR, output, 1 bit: request rejected.
REQ-015 SHALL have OCC, output, IDX_W bits: current stack occupancy, 0..DEPTH_MAX.
REQ-016 SHALL have COMMAND, output, 2 bits: stack command, same encoding as REQ_OP.
REQ-017 SHALL have INDEX, output, IDX_W bits: stack index.
REQ-018 SHALL have IO_DATA, inout, DATA_W bits: shared bidirectional stack data bus.
REQ-019 SHALL have STK_RESET, output, 1 bit: active-high stack reset, equal to ~RESET combinationally.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-021 SHALL hold REQ_READY=1 only in IDLE; a request is accepted at the rising edge where REQ_VALID&&REQ_READY; REQ_OP, REQ_DATA and REQ_INDEX are registered at that edge.
REQ-022 SHALL, on acceptance: PUSH with OCC==DEPTH_MAX, POP with OCC==0, or GET with REQ_INDEX>=OCC -> go to RESP with RSP_ERR=1, RSP_DATA=0, no stack command issued.
REQ-023 SHALL, on acceptance: NOP -> go to RESP with RSP_ERR=0, RSP_DATA=0, no stack command issued.
REQ-024 SHALL, on acceptance of any other request -> go to ISSUE.
REQ-025 SHALL, in ISSUE (one cycle), drive COMMAND=registered op and INDEX=registered index (0 for PUSH/POP); for PUSH, drive IO_DATA=registered data; the stack executes at the edge ending ISSUE.
REQ-026 SHALL, at the edge ending ISSUE: PUSH -> OCC+1 and go to RESP; POP/GET -> go to WAIT; POP also takes OCC-1.
REQ-027 SHALL, in WAIT (one cycle), hold COMMAND=NOP; the stack drives IO_DATA; IO_DATA is captured into RSP_DATA at the edge ending WAIT -> RESP.
REQ-028 SHALL assert RSP_VALID only in RESP, holding RSP_DATA and RSP_ERR stable until RSP_VALID&&RSP_READY, then go to IDLE.
REQ-029 SHALL give a minimum request-to-RSP_VALID latency of 2 cycles for PUSH, 3 for POP/GET, 1 for error/NOP.
REQ-030 SHALL keep IO_DATA at high impedance in every state except ISSUE with op PUSH.
REQ-031 SHALL drive COMMAND=NOP and INDEX=0 in IDLE, WAIT and RESP.
REQ-032 SHALL saturate OCC to 0..DEPTH_MAX; it never wraps.
REQ-033 SHALL ensure back-to-back requests are never overlapped: at most one stack command is outstanding.

Reset
REQ-034 SHALL, while RESET=0 (asynchronously, including mid-operation): state=IDLE, OCC=0, REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, COMMAND=NOP, INDEX=0, IO_DATA=Z, STK_RESET=1.
REQ-035 SHALL raise REQ_READY at the first rising edge after RESET deasserts.

Structure
REQ-036 SHALL place the op encoding enum, the FSM state enum and DEPTH_MAX in shared package stack_pkg, which is reused by the stack.
REQ-037 SHALL implement occupancy tracking in sub-module stack_occ_counter (inc/dec/clear, saturating, full/empty flags).

Verification
REQ-038 SHALL cover: after reset, PUSH 1..5 -> each RSP_ERR=0; OCC 1,2,3,4,5; IO_DATA equals the pushed value only during ISSUE.
REQ-039 SHALL cover: a 6th PUSH with value 6 at OCC=5 -> RSP_ERR=1, COMMAND stays NOP, OCC=5.
REQ-040 SHALL cover: GET index 0..4 after pushes 1..5 -> RSP_DATA 5,4,3,2,1; GET index 5 -> RSP_ERR=1.
REQ-041 SHALL cover: POP x5 -> RSP_DATA 5,4,3,2,1, OCC reaches 0; a 6th POP -> RSP_ERR=1, RSP_DATA=0.
REQ-042 SHALL cover: RESET low during WAIT of a POP -> immediate IDLE, OCC=0, IO_DATA=Z, RSP_VALID=0; then PUSH 7, GET 0 -> RSP_DATA=7.
REQ-043 SHALL cover: RSP_READY held low 4 cycles in RESP -> RSP_VALID, RSP_DATA and RSP_ERR stable, REQ_READY=0 throughout.
